// File: rtl/alu_arbiter_if.sv
// One requester's link to the ALU arbiter: operation request handshake plus
// result response handshake.
interface alu_arbiter_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_out;
  logic          rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept -> execute one cycle -> hold the registered result until consumed.
//
// state  | meaning
// S_IDLE | waiting for a request; grant is combinational this cycle
// S_EXEC | operand registers drive the ALU; result captured at the edge
// S_RESP | result presented to the granted requester until rsp_ready
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  req0,
  alu_arbiter_if.slave  req1,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_ctr,
  input  logic [DW-1:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          zero_q, zero_d;

  logic any_req;
  logic sel;
  logic rsp_take;

  // On a tie the requester that did not win last time gets the grant.
  assign any_req  = req0.req_valid | req1.req_valid;
  assign sel      = (req0.req_valid & req1.req_valid) ? ~last_q : req1.req_valid;
  assign rsp_take = gnt_q ? req1.rsp_ready : req0.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          last_d  = sel;
          op_d    = sel ? req1.req_op : req0.req_op;
          a_d     = sel ? req1.req_a  : req0.req_a;
          b_d     = sel ? req1.req_b  : req0.req_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_out;
        zero_d  = (alu_out == '0);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_take) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0.req_ready = 1'b0;
    req1.req_ready = 1'b0;
    req0.rsp_valid = 1'b0;
    req1.rsp_valid = 1'b0;
    req0.rsp_out   = '0;
    req1.rsp_out   = '0;
    req0.rsp_zero  = 1'b0;
    req1.rsp_zero  = 1'b0;
    if (state_q == S_IDLE && any_req) begin
      if (sel) req1.req_ready = 1'b1;
      else     req0.req_ready = 1'b1;
    end
    if (state_q == S_RESP) begin
      if (gnt_q) begin
        req1.rsp_valid = 1'b1;
        req1.rsp_out   = res_q;
        req1.rsp_zero  = zero_q;
      end else begin
        req0.rsp_valid = 1'b1;
        req0.rsp_out   = res_q;
        req0.rsp_zero  = zero_q;
      end
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_ctr = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the shared ALU.
module tb_alu_arbiter;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [2:0]    alu_ctr;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter_if #(.DW(DW)) if0 ();
  alu_arbiter_if #(.DW(DW)) if1 ();

  alu_arbiter #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (if0),
    .req1    (if1),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_out (alu_out)
  );

  // Shared ALU: SLL takes its shift amount from B[10:6].
  always_comb begin
    alu_out = '0;
    case (alu_ctr)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b101: alu_out = alu_a << alu_b[10:6];
      3'b110: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      if0.req_valid = v; if0.req_op = op; if0.req_a = a; if0.req_b = b;
    end else begin
      if1.req_valid = v; if1.req_op = op; if1.req_a = a; if1.req_b = b;
    end
  endtask

  task automatic clear_inputs();
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // Single-requester transaction: accept, EXEC, check response, consume.
  task automatic run_op(input int port, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_out,
                        input logic exp_z, input string tag);
    logic rdy;
    rdy = 1'b0;
    drive(port, 1'b1, op, a, b);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      rdy = (port == 0) ? if0.req_ready : if1.req_ready;
      if (rdy) break;
      cyc();
    end
    check({tag, "_acc"}, {31'd0, rdy}, 32'd1);
    cyc();
    drive(port, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    @(negedge clk);
    if (port == 0) begin
      check({tag, "_vld"}, {31'd0, if0.rsp_valid}, 32'd1);
      check({tag, "_out"}, if0.rsp_out, exp_out);
      check({tag, "_zero"}, {31'd0, if0.rsp_zero}, {31'd0, exp_z});
      check({tag, "_other"}, {31'd0, if1.rsp_valid}, 32'd0);
      if0.rsp_ready = 1'b1;
    end else begin
      check({tag, "_vld"}, {31'd0, if1.rsp_valid}, 32'd1);
      check({tag, "_out"}, if1.rsp_out, exp_out);
      check({tag, "_zero"}, {31'd0, if1.rsp_zero}, {31'd0, exp_z});
      check({tag, "_other"}, {31'd0, if0.rsp_valid}, 32'd0);
      if1.rsp_ready = 1'b1;
    end
    cyc();
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;
  endtask

  initial begin
    int gnt_port [6];
    int gnt_cyc  [6];
    int ngr;

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, if0.req_ready}, 32'd0);
    check("rst_ready1", {31'd0, if1.req_ready}, 32'd0);
    check("rst_rvld0", {31'd0, if0.rsp_valid}, 32'd0);
    check("rst_rvld1", {31'd0, if1.rsp_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctr", {29'd0, alu_ctr}, 32'd0);
    check("rst_out0", if0.rsp_out, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single ADD with latency and EXEC drive check
    drive(0, 1'b1, 3'b010, 32'd5, 32'd7);
    @(negedge clk);
    check("add_ready0", {31'd0, if0.req_ready}, 32'd1);
    check("add_ready1", {31'd0, if1.req_ready}, 32'd0);
    cyc();
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("add_exec_a", alu_a, 32'd5);
    check("add_exec_b", alu_b, 32'd7);
    check("add_exec_ctr", {29'd0, alu_ctr}, 32'd2);
    check("add_exec_rvld", {31'd0, if0.rsp_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("add_vld", {31'd0, if0.rsp_valid}, 32'd1);
    check("add_out", if0.rsp_out, 32'd12);
    check("add_zero", {31'd0, if0.rsp_zero}, 32'd0);
    check("add_other", {31'd0, if1.rsp_valid}, 32'd0);
    if0.rsp_ready = 1'b1;
    cyc();
    if0.rsp_ready = 1'b0;

    // Tie after reset: requester 0 first, requester 1 three cycles later
    do_reset();
    drive(0, 1'b1, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    drive(1, 1'b1, 3'b001, 32'h1, 32'h2);
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    check("tie_ready0", {31'd0, if0.req_ready}, 32'd1);
    check("tie_ready1", {31'd0, if1.req_ready}, 32'd0);
    cyc();
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("tie_exec_ready1", {31'd0, if1.req_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check("tie_out0", if0.rsp_out, 32'h00F0_00F0);
    check("tie_rvld1", {31'd0, if1.rsp_valid}, 32'd0);
    check("tie_resp_ready1", {31'd0, if1.req_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check("tie_ready1_late", {31'd0, if1.req_ready}, 32'd1);
    cyc();
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    @(negedge clk);
    check("tie_vld1", {31'd0, if1.rsp_valid}, 32'd1);
    check("tie_out1", if1.rsp_out, 32'h3);
    cyc();
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;

    // Fairness under continuous dual requests
    drive(0, 1'b1, 3'b010, 32'd10, 32'd20);
    drive(1, 1'b1, 3'b011, 32'hFF, 32'h0F);
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      @(negedge clk);
      if (if0.req_ready) begin gnt_port[ngr] = 0; gnt_cyc[ngr] = c; ngr++; end
      else if (if1.req_ready) begin gnt_port[ngr] = 1; gnt_cyc[ngr] = c; ngr++; end
      if (if0.rsp_valid) check("fair_out0", if0.rsp_out, 32'd30);
      if (if1.rsp_valid) check("fair_out1", if1.rsp_out, 32'hF0);
      cyc();
    end
    check("fair_count", ngr, 6);
    for (int i = 0; i < ngr; i++) begin
      check($sformatf("fair_gnt%0d", i), gnt_port[i], i % 2);
      if (i > 0) check($sformatf("fair_gap%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 3);
    end
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    @(negedge clk);
    check("fair_last_vld1", {31'd0, if1.rsp_valid}, 32'd1);
    cyc();
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;

    // Backpressure with zero result; req0 waits behind the stalled response
    drive(1, 1'b1, 3'b110, 32'h1234, 32'h1234);
    @(negedge clk);
    check("bp_ready1", {31'd0, if1.req_ready}, 32'd1);
    cyc();
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_vld_%0d", i), {31'd0, if1.rsp_valid}, 32'd1);
      check($sformatf("bp_out_%0d", i), if1.rsp_out, 32'd0);
      check($sformatf("bp_zero_%0d", i), {31'd0, if1.rsp_zero}, 32'd1);
      check($sformatf("bp_noacc_%0d", i), {31'd0, if0.req_ready}, 32'd0);
      cyc();
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_noacc", {31'd0, if0.req_ready}, 32'd0);
    cyc();
    if1.rsp_ready = 1'b0;
    run_op(0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'd1, 1'b0, "slt");
    run_op(0, 3'b101, 32'd3, 32'h0000_0080, 32'd12, 1'b0, "sll");
    run_op(1, 3'b111, 32'hFFFF, 32'h1, 32'd0, 1'b1, "op7");

    // Reset during EXEC discards the operation
    drive(1, 1'b1, 3'b011, 32'hF, 32'h3);
    @(negedge clk);
    check("rx_ready1", {31'd0, if1.req_ready}, 32'd1);
    cyc();
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("rx_exec_a", alu_a, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_alu_ctr", {29'd0, alu_ctr}, 32'd0);
    check("rx_rvld1", {31'd0, if1.rsp_valid}, 32'd0);
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      check($sformatf("rx_no_rsp_%0d", i), {31'd0, if1.rsp_valid}, 32'd0);
    end
    if1.rsp_ready = 1'b0;
    cyc();
    drive(0, 1'b1, 3'b000, 32'd1, 32'd1);
    drive(1, 1'b1, 3'b000, 32'd1, 32'd1);
    @(negedge clk);
    check("rx_tie_ready0", {31'd0, if0.req_ready}, 32'd1);
    check("rx_tie_ready1", {31'd0, if1.req_ready}, 32'd0);
    cyc();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
